ascon_dispatch: RTL



---
 rtl/ascon_dispatch_pkg.sv | 45 ++++
 rtl/dispatch_order_fifo.sv | 50 +++++
 rtl/ascon_dispatch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ascon_dispatch_pkg.sv
// Shared types, bus widths and helper functions for the multi-core ASCON dispatcher.
package ascon_dispatch_pkg;

  localparam int unsigned KEY_W     = 32;
  localparam int unsigned BD_W      = 32;
  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned VB_W      = 4;
  // Upper bound on core lanes; the round-robin search is sized for this.
  localparam int unsigned MAX_CORES = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSel    = 2'd1,
    StStream = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Core index width; a single lane still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First available lane at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_search(input logic [MAX_CORES-1:0] avail,
                                         input int unsigned          ptr,
                                         input int unsigned          n);
    rr_pick_t    pick;
    int unsigned k;
    pick = '0;
    for (int unsigned i = 0; i < MAX_CORES; i++) begin
      k = ptr + i;
      if (k >= n) k = k - n;
      if ((i < n) && !pick.found && avail[3'(k)]) begin
        pick.found = 1'b1;
        pick.idx   = 3'(k);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dispatch_order_fifo.sv
// Order FIFO of core indices: records which lane each in-flight message went to, in
// arrival order, so that core outputs can be returned in that same order.
module dispatch_order_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
                     (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AddrW-1:0]];

  // Pointer update; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AddrW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ascon_dispatch.sv
// Multi-core ASCON dispatcher: hands each whole message to an idle core chosen
// round-robin, and returns core outputs to the DMA in message-arrival order.
module ascon_dispatch
  import ascon_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES   = 2,
  parameter int unsigned ORDER_DEPTH = 4,
  parameter int unsigned IDXW        = idx_width(NUM_CORES)
) (
  input  logic                        iClk,
  input  logic                        iRst,
  // DMA key / BDI streams
  input  logic                        iKeyVld,
  input  logic                        iKeyLast,
  input  logic [KEY_W-1:0]            iKey,
  output logic                        oKeyRdy,
  input  logic                        iBdiVld,
  input  logic                        iBdiLast,
  input  logic                        iEoi,
  input  logic [TYPE_W-1:0]           iBdiType,
  input  logic [VB_W-1:0]             iBdiVldByte,
  input  logic [BD_W-1:0]             iBdi,
  output logic                        oBdiRdy,
  // DMA output stream and status
  output logic                        oBdoVld,
  output logic                        oBdoLast,
  output logic [TYPE_W-1:0]           oBdoType,
  output logic [VB_W-1:0]             oBdoVldByte,
  output logic [BD_W-1:0]             oBdo,
  input  logic                        iBdoRdy,
  output logic                        oAuthVld,
  output logic                        oTagMatch,
  output logic                        oDone,
  // Per-core input lanes
  output logic [NUM_CORES-1:0]        oKeyVld,
  output logic [NUM_CORES-1:0]        oKeyLast,
  output logic [NUM_CORES*KEY_W-1:0]  oKey,
  output logic [NUM_CORES-1:0]        oBdiVld,
  output logic [NUM_CORES-1:0]        oBdiLast,
  output logic [NUM_CORES-1:0]        oEoi,
  output logic [NUM_CORES*TYPE_W-1:0] oBdiType,
  output logic [NUM_CORES*VB_W-1:0]   oBdiVldByte,
  output logic [NUM_CORES*BD_W-1:0]   oBdi,
  output logic [NUM_CORES-1:0]        oBdoRdy,
  // Per-core return lanes
  input  logic [NUM_CORES-1:0]        iKeyRdy,
  input  logic [NUM_CORES-1:0]        iBdiRdy,
  input  logic [NUM_CORES-1:0]        iRdy,
  input  logic [NUM_CORES-1:0]        iDone,
  input  logic [NUM_CORES-1:0]        iBdoVld,
  input  logic [NUM_CORES-1:0]        iBdoLast,
  input  logic [NUM_CORES-1:0]        iAuthVld,
  input  logic [NUM_CORES-1:0]        iTagMatch,
  input  logic [NUM_CORES*TYPE_W-1:0] iBdoType,
  input  logic [NUM_CORES*VB_W-1:0]   iBdoVldByte,
  input  logic [NUM_CORES*BD_W-1:0]   iBdo,
  // Status
  output logic [NUM_CORES-1:0]        oCoreBusy,
  output logic                        oFull
);

  state_e               r_state;
  logic [IDXW-1:0]      r_cur_idx;
  logic [IDXW-1:0]      r_rr_ptr;
  logic [NUM_CORES-1:0] r_busy;

  logic [MAX_CORES-1:0] w_avail;
  rr_pick_t             w_pick;
  logic [IDXW-1:0]      w_pick_idx;
  logic [IDXW-1:0]      w_next_ptr;
  logic [NUM_CORES-1:0] w_pick_oh;
  logic [NUM_CORES-1:0] w_cur_oh;
  logic [NUM_CORES-1:0] w_head_oh;
  logic [NUM_CORES-1:0] w_busy_next;
  logic [IDXW-1:0]      w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  // Lane selection: idle-and-ready lanes searched from the round-robin pointer.
  always_comb begin
    w_avail                = '0;
    w_avail[NUM_CORES-1:0] = iRdy & ~r_busy;
    w_pick                 = rr_search(w_avail, 32'(r_rr_ptr), NUM_CORES);
    w_pick_idx             = IDXW'(w_pick.idx);
    w_next_ptr             = (32'(w_pick.idx) == NUM_CORES - 1) ? '0
                                                                : IDXW'(w_pick.idx + 3'd1);
    w_push                 = (r_state == StSel) && w_pick.found && !w_full;
    w_pop                  = |(iDone & w_head_oh);
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      w_pick_oh[k] = (32'(w_pick.idx) == k);
      w_cur_oh[k]  = (r_state == StStream) && (32'(r_cur_idx) == k);
      w_head_oh[k] = !w_empty && (32'(w_head) == k);
    end
  end

  // Input FSM: wait for traffic, claim a lane, then stream until end-of-input.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= StIdle;
      r_cur_idx <= '0;
      r_rr_ptr  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (iKeyVld || iBdiVld) r_state <= StSel;
        end
        StSel: begin
          if (w_push) begin
            r_cur_idx <= w_pick_idx;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= StStream;
          end
        end
        StStream: begin
          if (iBdiVld && oBdiRdy && iEoi) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Busy bits: cleared when the head lane finishes, set when a lane is claimed.
  always_comb begin
    w_busy_next = r_busy;
    if (w_pop)  w_busy_next = w_busy_next & ~w_head_oh;
    if (w_push) w_busy_next = w_busy_next | w_pick_oh;
  end

  // Busy register.
  always_ff @(posedge iClk) begin
    if (iRst) r_busy <= '0;
    else      r_busy <= w_busy_next;
  end

  dispatch_order_fifo #(
    .Depth (ORDER_DEPTH),
    .Width (IDXW)
  ) u_order_fifo (
    .i_clk   (iClk),
    .i_rst   (iRst),
    .i_push  (w_push),
    .i_data  (w_pick_idx),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Forward path: only the claimed lane sees the DMA streams while streaming.
  always_comb begin
    oKeyVld     = '0;
    oKeyLast    = '0;
    oKey        = '0;
    oBdiVld     = '0;
    oBdiLast    = '0;
    oEoi        = '0;
    oBdiType    = '0;
    oBdiVldByte = '0;
    oBdi        = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (w_cur_oh[k]) begin
        oKeyVld[k]                    = iKeyVld;
        oKeyLast[k]                   = iKeyLast;
        oKey[k*KEY_W +: KEY_W]        = iKey;
        oBdiVld[k]                    = iBdiVld;
        oBdiLast[k]                   = iBdiLast;
        oEoi[k]                       = iEoi;
        oBdiType[k*TYPE_W +: TYPE_W]  = iBdiType;
        oBdiVldByte[k*VB_W +: VB_W]   = iBdiVldByte;
        oBdi[k*BD_W +: BD_W]          = iBdi;
      end
    end
    oKeyRdy = |(iKeyRdy & w_cur_oh);
    oBdiRdy = |(iBdiRdy & w_cur_oh);
  end

  // Return path: the FIFO head lane owns the DMA output; all else stalls.
  always_comb begin
    oBdoVld     = 1'b0;
    oBdoLast    = 1'b0;
    oBdoType    = '0;
    oBdoVldByte = '0;
    oBdo        = '0;
    oAuthVld    = 1'b0;
    oTagMatch   = 1'b0;
    oDone       = 1'b0;
    oBdoRdy     = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (w_head_oh[k]) begin
        oBdoVld     = iBdoVld[k];
        oBdoLast    = iBdoLast[k];
        oBdoType    = iBdoType[k*TYPE_W +: TYPE_W];
        oBdoVldByte = iBdoVldByte[k*VB_W +: VB_W];
        oBdo        = iBdo[k*BD_W +: BD_W];
        oAuthVld    = iAuthVld[k];
        oTagMatch   = iTagMatch[k];
        oDone       = iDone[k];
        oBdoRdy[k]  = iBdoRdy;
      end
    end
  end

  assign oCoreBusy = r_busy;
  assign oFull     = w_full;

endmodule
